// File: rtl/snake_sound_pkg.sv
// Shared definitions for the snake game sound sequencer: sound codes,
// default tune lengths and the sequencer FSM states.
package snake_sound_pkg;

    localparam logic [1:0] SND_MELODY = 2'd0;
    localparam logic [1:0] SND_EAT    = 2'd1;
    localparam logic [1:0] SND_OVER   = 2'd2;

    localparam int unsigned TACT_CYCLES_DEF = 2097152;
    localparam int unsigned LEN_MELODY_DEF  = 102;
    localparam int unsigned LEN_EAT_DEF     = 2;
    localparam int unsigned LEN_OVER_DEF    = 9;
    localparam int unsigned GAP_TACTS_DEF   = 2;

    // Bit positions inside the {over, start, eat} pending vector
    localparam int unsigned PEND_EAT   = 0;
    localparam int unsigned PEND_START = 1;
    localparam int unsigned PEND_OVER  = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALL,
        PLAY,
        GAP
    } snd_state_t;

endpackage

// File: rtl/sound_event_ctrl_tact_timer.sv
// Tact timer: counts target tacts of TACT_CYCLES clocks each after a start
// pulse and raises done for one cycle on the terminal count.
module tact_timer #(
    parameter int unsigned TACT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] target,
    output logic       done
);

    localparam int unsigned    CW       = (TACT_CYCLES > 1) ? $clog2(TACT_CYCLES) : 1;
    localparam logic [CW-1:0]  CYC_LAST = CW'(TACT_CYCLES - 1);

    logic [CW-1:0] cyc_q;
    logic [6:0]    tact_q;
    logic [6:0]    target_q;
    logic          run_q;

    // Combinational from registered counters so the FSM can leave in the terminal cycle
    assign done = run_q && (tact_q == target_q - 7'd1) && (cyc_q == CYC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q    <= '0;
            tact_q   <= '0;
            target_q <= '0;
            run_q    <= 1'b0;
        end else if (start) begin
            cyc_q    <= '0;
            tact_q   <= '0;
            target_q <= target;
            run_q    <= (target != 7'd0);
        end else if (run_q) begin
            if (done) begin
                run_q <= 1'b0;
            end
            if (cyc_q == CYC_LAST) begin
                cyc_q  <= '0;
                tact_q <= tact_q + 7'd1;
            end else begin
                cyc_q <= cyc_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sound_event_ctrl.sv
// Sound event sequencer: latches game-event pulses as pending requests and
// issues them one at a time to the tone player, never interrupting a tune.
module sound_event_ctrl
    import snake_sound_pkg::*;
#(
    parameter int unsigned TACT_CYCLES = TACT_CYCLES_DEF,
    parameter int unsigned LEN_MELODY  = LEN_MELODY_DEF,
    parameter int unsigned LEN_EAT     = LEN_EAT_DEF,
    parameter int unsigned LEN_OVER    = LEN_OVER_DEF,
    parameter int unsigned GAP_TACTS   = GAP_TACTS_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ev_start,
    input  logic       ev_eat,
    input  logic       ev_over,
    input  logic       mute,
    output logic [1:0] sound_code,
    output logic       sound_call,
    output logic       busy,
    output logic [2:0] pending
);

    localparam logic [6:0] L_MELODY = 7'(LEN_MELODY);
    localparam logic [6:0] L_EAT    = 7'(LEN_EAT);
    localparam logic [6:0] L_OVER   = 7'(LEN_OVER);
    localparam logic [6:0] L_GAP    = 7'(GAP_TACTS);

    snd_state_t state_q, state_d;
    logic [2:0] pend_q, pend_clr;
    logic [1:0] sel_code_q, sel_code_d;
    logic [6:0] sel_len_q, sel_len_d;
    logic       timer_start, timer_done;
    logic [6:0] timer_target;
    logic [1:0] code_q;
    logic       call_q, busy_q;

    tact_timer #(
        .TACT_CYCLES(TACT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .start (timer_start),
        .target(timer_target),
        .done  (timer_done)
    );

    always_comb begin
        state_d      = state_q;
        sel_code_d   = sel_code_q;
        sel_len_d    = sel_len_q;
        pend_clr     = '0;
        timer_start  = 1'b0;
        timer_target = sel_len_q;
        case (state_q)
            IDLE: begin
                if (!mute && (pend_q != 3'b000)) begin
                    state_d = LOAD;
                    if (pend_q[PEND_OVER]) begin
                        sel_code_d         = SND_OVER;
                        sel_len_d          = L_OVER;
                        pend_clr[PEND_OVER] = 1'b1;
                    end else if (pend_q[PEND_START]) begin
                        sel_code_d          = SND_MELODY;
                        sel_len_d           = L_MELODY;
                        pend_clr[PEND_START] = 1'b1;
                    end else begin
                        sel_code_d        = SND_EAT;
                        sel_len_d         = L_EAT;
                        pend_clr[PEND_EAT] = 1'b1;
                    end
                end
            end
            LOAD: state_d = CALL;
            CALL: begin
                state_d     = PLAY;
                timer_start = 1'b1;
            end
            PLAY: begin
                if (timer_done) begin
                    if (GAP_TACTS == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d      = GAP;
                        timer_start  = 1'b1;
                        timer_target = L_GAP;
                    end
                end
            end
            GAP: begin
                if (timer_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            sel_code_q <= SND_EAT;
            sel_len_q  <= '0;
            code_q     <= SND_EAT;
            call_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_code_q <= sel_code_d;
            sel_len_q  <= sel_len_d;
            // A pulse coinciding with its own clear re-arms the flag
            pend_q     <= mute ? 3'b000 : ((pend_q & ~pend_clr) | {ev_over, ev_start, ev_eat});
            if (state_q == LOAD) begin
                code_q <= sel_code_q;
            end
            if (state_q == CALL) begin
                call_q <= ~call_q;
            end
            busy_q <= (state_d != IDLE);
        end
    end

    assign sound_code = code_q;
    assign sound_call = call_q;
    assign busy       = busy_q;
    assign pending    = pend_q;

endmodule
